mem_access_unit: RTL

//  Load/store stage between the single-cycle core and a data RAM/bus with variable latency.

---
 rtl/mem_access_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage between a single-cycle core and a variable-latency data bus.
// Formats byte/half/word accesses, runs req/gnt/rvalid, stalls the core and muxes writeback data.
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    input  logic              ena_rd,
    input  logic              ena_wr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       alu_out_ext,
    input  logic [31:0]       dataram_wr,
    input  logic              MemtoReg,
    output logic              stall,
    output logic [31:0]       datareg_wr,
    output logic              misaligned,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;
    logic [31:0]      load_q_r;
    logic [2:0]       f3_r;
    logic [1:0]       lane_r;
    logic             access_s;
    logic             aligned_s;
    logic             start_s;
    logic             mis_s;
    logic             timeout_s;
    logic             abort_s;

    // Size is taken from funct3[1:0]: 00 byte, 01 half, anything else a full word.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (a[0] == 1'b0);
            default: ok = (a == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'hF;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{d[7:0]}};
            2'b01:   wd = {2{d[15:0]}};
            default: wd = d;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd >> {a, 3'b000};
        case (f3[1:0])
            2'b00:   v = f3[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   v = f3[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: v = rd;
        endcase
        return v;
    endfunction

    assign access_s  = ena_rd | ena_wr;
    assign aligned_s = is_aligned(funct3, alu_out_ext[1:0]);
    assign start_s   = (state_r == IDLE) & access_s & aligned_s;
    assign mis_s     = (state_r == IDLE) & access_s & ~aligned_s;
    assign timeout_s = (cnt_r == CNT_LAST);
    // A grant on the last allowed cycle only saves a store; a load would still need rvalid.
    assign abort_s   = timeout_s & (((state_r == REQ) & ~(mem_gnt & mem_we)) |
                                    ((state_r == WAIT_R) & ~mem_rvalid));

    // Misaligned loads commit zero in the same cycle, before load_q has been cleared.
    assign datareg_wr = MemtoReg ? (mis_s ? 32'h0000_0000 : load_q_r) : alu_out_ext;

    // State register
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_nxt_s = REQ;
                else         state_nxt_s = IDLE;
            end
            REQ: begin
                if (mem_gnt && mem_we) state_nxt_s = DONE;
                else if (timeout_s)    state_nxt_s = DONE;
                else if (mem_gnt)      state_nxt_s = WAIT_R;
                else                   state_nxt_s = REQ;
            end
            WAIT_R: begin
                if (mem_rvalid)     state_nxt_s = DONE;
                else if (timeout_s) state_nxt_s = DONE;
                else                state_nxt_s = WAIT_R;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; reset forces the handshake and core stall low immediately
    always_comb begin
        stall      = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        mem_req    = 1'b0;
        if (!RST_n) begin
            stall = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    stall      = start_s;
                    misaligned = mis_s;
                end
                REQ: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                end
                WAIT_R:  stall = 1'b1;
                DONE:    bus_err = err_r;
                default: stall = 1'b0;
            endcase
        end
    end

    // Request capture, timeout counter and load data register
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0000_0000;
            f3_r      <= 3'b000;
            lane_r    <= 2'b00;
            cnt_r     <= '0;
            err_r     <= 1'b0;
            load_q_r  <= 32'h0000_0000;
        end else if (start_s) begin
            mem_we    <= ena_wr;
            mem_addr  <= {alu_out_ext[ADDR_W-1:2], 2'b00};
            mem_be    <= store_be(funct3, alu_out_ext[1:0]);
            mem_wdata <= store_data(funct3, dataram_wr);
            f3_r      <= funct3;
            lane_r    <= alu_out_ext[1:0];
            cnt_r     <= '0;
            err_r     <= 1'b0;
        end else if (mis_s) begin
            if (!ena_wr) load_q_r <= 32'h0000_0000;
            else         load_q_r <= load_q_r;
        end else if ((state_r == REQ) || (state_r == WAIT_R)) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (abort_s) begin
                load_q_r <= 32'h0000_0000;
                err_r    <= 1'b1;
            end else if ((state_r == WAIT_R) && mem_rvalid) begin
                load_q_r <= load_fmt(f3_r, lane_r, mem_rdata);
            end else begin
                load_q_r <= load_q_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule
